// File: rtl/mesi_snoop_responder.sv
// mesi_snoop_responder: snoop-side MESI responder holding tag/state/data per line and flushing dirty lines as a word burst
module mesi_snoop_responder #(
  parameter int CACHE_LINES = 64,
  parameter int TAG_W = 22,
  parameter int WORDS = 4,
  localparam int IDX_W = $clog2(CACHE_LINES),
  localparam int BW = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  snp_valid,
  output logic                  snp_ready,
  input  logic [1:0]            snp_cmd,
  input  logic [31:0]           snp_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic                  rsp_shared,
  output logic                  rsp_dirty,
  output logic                  rsp_err,
  output logic                  flush_valid,
  input  logic                  flush_ready,
  output logic [31:0]           flush_data,
  output logic                  flush_last,
  input  logic                  loc_we,
  output logic                  loc_ready,
  input  logic [IDX_W-1:0]      loc_index,
  input  logic [TAG_W-1:0]      loc_tag,
  input  logic [1:0]            loc_state,
  input  logic [32*WORDS-1:0]   loc_data
);
  typedef enum logic [1:0] {IDLE, LOOKUP, RESP, FLUSH} fsm_t;
  localparam logic [1:0] ST_M = 2'b00, ST_E = 2'b01, ST_S = 2'b10, ST_I = 2'b11;
  localparam logic [1:0] BUS_RD = 2'b00, BUS_UPGR = 2'b10, BUS_RSV = 2'b11;
  fsm_t st;
  logic [1:0] cmd_r;
  logic [TAG_W-1:0] tag_r;
  logic [IDX_W-1:0] idx_r;
  logic [BW-1:0] beat;
  logic [32*WORDS-1:0] line_r;
  logic [TAG_W-1:0] tag_mem [CACHE_LINES];
  logic [32*WORDS-1:0] data_mem [CACHE_LINES];
  logic [1:0] state_mem [CACHE_LINES];
  logic [1:0] cur, nxt;
  logic hit, n_shared, n_dirty, n_err;
  logic unused_offset;
  assign unused_offset = ^snp_addr[3:0];
  assign loc_ready = st == IDLE;
  assign snp_ready = st == IDLE && !loc_we;
  assign rsp_valid = st == RESP;
  assign flush_valid = st == FLUSH;
  assign flush_data = flush_valid ? line_r[{beat, 5'd0} +: 32] : '0;
  assign flush_last = flush_valid && beat == BW'(WORDS - 1);
  assign cur = state_mem[idx_r];
  assign hit = cmd_r != BUS_RSV && cur != ST_I && tag_mem[idx_r] == tag_r;
  // MESI transition for the snooped line; BusRd keeps a shared copy, everything else invalidates
  always_comb begin
    nxt = hit ? (cmd_r == BUS_RD ? ST_S : ST_I) : cur;
    n_shared = hit && cmd_r == BUS_RD;
    n_dirty = hit && cur == ST_M && cmd_r != BUS_UPGR;
    n_err = cmd_r == BUS_RSV || (hit && cmd_r == BUS_UPGR && cur != ST_S);
  end
  // tag/data arrays are not reset; the line image is latched at lookup for the flush burst
  always_ff @(posedge clk) begin
    if (reset && loc_ready && loc_we) begin
      tag_mem[loc_index] <= loc_tag;
      data_mem[loc_index] <= loc_data;
    end
    if (st == LOOKUP) line_r <= data_mem[idx_r];
  end
  // control FSM plus line state array; local installs beat a simultaneous snoop in IDLE
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= IDLE;
      cmd_r <= '0;
      tag_r <= '0;
      idx_r <= '0;
      beat <= '0;
      rsp_hit <= 1'b0;
      rsp_shared <= 1'b0;
      rsp_dirty <= 1'b0;
      rsp_err <= 1'b0;
      for (int i = 0; i < CACHE_LINES; i++) state_mem[i] <= ST_I;
    end else
      case (st)
        IDLE:
          if (loc_we) state_mem[loc_index] <= loc_state;
          else if (snp_valid) begin
            cmd_r <= snp_cmd;
            tag_r <= snp_addr[31 -: TAG_W];
            idx_r <= snp_addr[4 +: IDX_W];
            st <= LOOKUP;
          end
        LOOKUP: begin
          state_mem[idx_r] <= nxt;
          rsp_hit <= hit;
          rsp_shared <= n_shared;
          rsp_dirty <= n_dirty;
          rsp_err <= n_err;
          beat <= '0;
          st <= RESP;
        end
        RESP: if (rsp_ready) st <= rsp_dirty ? FLUSH : IDLE;
        FLUSH:
          if (flush_ready) begin
            beat <= beat + 1'b1;
            if (flush_last) st <= IDLE;
          end
      endcase
endmodule

// File: doc/mesi_snoop_responder.md
Name: mesi_snoop_responder

Overview:
- Snoop-side end of the MESI protocol for one core's private cache. It answers coherence requests (BusRd, BusRdX, BusUpgr) driven by the other core's cache controller.
- Holds the per-line tag and MESI state and downgrades or invalidates lines. Reports hit, shared and dirty status, and flushes a Modified line as a 4-word burst.
- Sits between the shared coherence bus and the local cache arrays. The local cache controller installs lines through a line-write port.

Parameters:
- CACHE_LINES, 64, lines per core; direct-mapped; index = addr[9:4].
- TAG_W, 22, tag width; tag = addr[31:10].
- WORDS, 4, 32-bit words per line; offset = addr[3:2].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- snp_valid  in  1  snoop request valid.
- snp_ready  out  1  snoop accept; transfer occurs when snp_valid && snp_ready.
- snp_cmd  in  2  00 BusRd, 01 BusRdX, 10 BusUpgr, 11 reserved.
- snp_addr  in  32  snooped byte address.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_hit  out  1  tag match and state != INVALID, sampled at lookup.
- rsp_shared  out  1  line retained after the snoop (new state SHARED).
- rsp_dirty  out  1  line was MODIFIED; a flush burst follows.
- rsp_err  out  1  reserved cmd, or BusUpgr hitting M/E.
- flush_valid  out  1  flush beat valid.
- flush_ready  in  1  flush beat accept.
- flush_data  out  32  flush word.
- flush_last  out  1  marks beat 3.
- loc_we  in  1  local line install.
- loc_ready  out  1  high only in IDLE.
- loc_index  in  6  line index.
- loc_tag  in  TAG_W  line tag.
- loc_state  in  2  MESI state to install.
- loc_data  in  128  line data; word0 = bits [31:0].

Behaviour:
- MESI encoding: M=00, E=01, S=10, I=11.
- Reset (reset=0, asynchronous):
  - All line states become INVALID; the tag and data arrays are not reset.
  - FSM goes to IDLE.
  - All outputs are 0 except loc_ready=1 and snp_ready=1.
  - Reset asserted mid-transaction aborts any response or flush in progress with no partial state update.
- FSM states: IDLE, LOOKUP, RESP, FLUSH.
- IDLE:
  - snp_ready=1 unless loc_we=1.
  - loc_we with loc_ready=1 writes tag, state and data for loc_index. It takes priority over a simultaneous snoop; snp_ready=0 that cycle.
  - An accepted snoop registers cmd and addr, then goes to LOOKUP.
  - loc_we outside IDLE is ignored.
- LOOKUP (1 cycle): read the line, compute hit, compute next state, commit the state write, go to RESP. No data change.
- Next-state table:
  - Miss or I: no change; hit=0, shared=0, dirty=0.
  - M on BusRd: goes to S; shared=1, dirty=1.
  - M on BusRdX: goes to I; dirty=1.
  - E on BusRd: goes to S; shared=1.
  - E on BusRdX: goes to I.
  - S on BusRd: stays S; shared=1.
  - S on BusRdX: goes to I.
  - S on BusUpgr: goes to I.
  - M or E on BusUpgr: goes to I; err=1; dirty=0 (no flush).
  - Reserved cmd 11: no change; err=1; hit=0.
- RESP:
  - rsp_valid=1 with the rsp_* fields held stable until rsp_ready.
  - On acceptance: go to FLUSH if dirty, else IDLE.
- FLUSH:
  - Beats are word0..word3 in order, from the data captured at LOOKUP.
  - A 2-bit beat counter advances on flush_valid && flush_ready.
  - flush_last=1 on beat 3. After the beat-3 handshake, go to IDLE.
  - flush_valid and flush_data hold while flush_ready=0.
- Timing: snoop accepted at edge T; rsp_valid is high from T+2. With rsp_ready=1, the first flush beat is valid at T+3.
- Throughput: one snoop per transaction; snp_ready=0 outside IDLE.

Test Plan:
- After reset, loc install idx 5 with tag 0x0ABCD, state M, data {0x11,0x22,0x33,0x44}, then BusRd to 0x02AF3450 → rsp at T+2 with hit=1, shared=1, dirty=1. Flush beats are 0x11, 0x22, 0x33, 0x44 with last on 0x44. A later BusRd to the same address gives hit=1, shared=1, dirty=0.
- Install E at idx 5, then BusRdX to the same address → hit=1, shared=0, dirty=0, no flush. A following BusRd → hit=0.
- Install S, then BusUpgr → hit=1, line becomes I. Install M, then BusUpgr → err=1, dirty=0, no flush, line becomes I.
- Backpressure: hold rsp_ready=0 for 3 cycles, then toggle flush_ready 1,0,1,0,1,1 → fields and data stay stable while stalled. Exactly 4 beats, no drop or duplicate. snp_ready=0 throughout.
- loc_we and snp_valid in the same IDLE cycle → install wins, snp_ready=0 that cycle. The snoop is accepted the next cycle and sees the installed state. Reserved cmd 11 → err=1, hit=0.
- Assert reset during flush beat 1 → flush_valid=0 immediately. After release, a BusRd to that line gives hit=0.
